asp_net_arbiter: RTL and testbench

- Round-robin arbiter and transmit sequencer sharing one network transmit link among NUM_REQ ASP transmitters.
- Sits between the ASP network_data_ready_out / network_data_tag_out / network_ACK_in ports and the single network link.
- Per transfer: latches the winner's data+tag word, drives it onto the link, waits for ACK, retries on timeout, and returns ACK or fail to the requester.

---
 rtl/asp_net_arbiter.sv | 162 ++++++++++++++++
 tb/tb_asp_net_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asp_net_arbiter.sv
// rtl/asp_net_arbiter.sv - round-robin arbiter and transmit sequencer for the shared network link
// Latches the winning requester's word, sends it, waits for ACK with retries, then reports ACK or fail.
module asp_net_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_SIZE   = 32,
    parameter int TAG_SIZE    = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQ-1:0]                            req_data_ready_in,
    input  logic [NUM_REQ*(DATA_SIZE+TAG_SIZE)-1:0]       req_data_tag_in,
    output logic [NUM_REQ-1:0]                            req_ACK_out,
    output logic [NUM_REQ-1:0]                            req_fail_out,
    output logic [NUM_REQ-1:0]                            grant_out,
    output logic                                          network_data_ready_out,
    output logic [DATA_SIZE+TAG_SIZE-1:0]                 network_data_tag_out,
    input  logic                                          network_ACK_in,
    output logic                                          busy_out
);

    localparam int W     = DATA_SIZE + TAG_SIZE;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [IDX_W:0]   NREQ_W    = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_DONE_OK,
        S_DONE_FAIL
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [TMR_W-1:0]   r_timer;
    logic [RTY_W-1:0]   r_retry;
    logic [W-1:0]       r_word;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_fail;
    logic               r_net_ready;
    logic               r_busy;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W:0]     w_idx;
    logic [W-1:0]       w_word;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic [IDX_W-1:0]   w_next_ptr;

    // Scan requesters starting at the round-robin pointer, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!w_found && req_data_ready_in[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_word = req_data_tag_in[i*W +: W];
            end
        end
    end

    assign w_sel_onehot   = NUM_REQ'(1) << w_sel;
    assign w_owner_onehot = NUM_REQ'(1) << r_gidx;
    assign w_next_ptr     = (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_timer     <= '0;
            r_retry     <= '0;
            r_word      <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_fail      <= '0;
            r_net_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_fail      <= '0;
            r_net_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gidx      <= w_sel;
                        r_word      <= w_word;
                        r_grant     <= w_sel_onehot;
                        r_retry     <= '0;
                        r_net_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // An ACK arriving on the timeout edge still counts as success.
                    if (network_ACK_in) begin
                        r_ack   <= w_owner_onehot;
                        r_state <= S_DONE_OK;
                    end else if (r_timer == TMR_LAST) begin
                        if (r_retry < RTY_MAX) begin
                            r_retry     <= r_retry + 1'b1;
                            r_net_ready <= 1'b1;
                            r_state     <= S_SEND;
                        end else begin
                            r_fail  <= w_owner_onehot;
                            r_state <= S_DONE_FAIL;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE_OK, S_DONE_FAIL: begin
                    r_rr_ptr <= w_next_ptr;
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ACK_out            = r_ack;
    assign req_fail_out           = r_fail;
    assign grant_out              = r_grant;
    assign network_data_ready_out = r_net_ready;
    assign network_data_tag_out   = r_word;
    assign busy_out               = r_busy;

endmodule

// File: tb/tb_asp_net_arbiter.sv
// tb/tb_asp_net_arbiter.sv - self-checking bench for asp_net_arbiter
// Transaction-level model: round-robin winner, per-attempt ACK delays, expected pulse timing.
module tb_asp_net_arbiter;

    localparam int N  = 4;
    localparam int DS = 32;
    localparam int TS = 8;
    localparam int W  = DS + TS;
    localparam int TO = 16;
    localparam int MR = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_tag;
    logic [N-1:0]   ack_out;
    logic [N-1:0]   fail_out;
    logic [N-1:0]   grant;
    logic           net_ready;
    logic [W-1:0]   net_tag;
    logic           net_ack;
    logic           busy;

    int vectors = 0;
    int errors  = 0;
    int model_ptr = 0;

    logic [W-1:0] words [N][$];
    int d_plan[$];
    int order_log[$];
    int outcome_log[$];
    int tries_log[$];

    asp_net_arbiter #(
        .NUM_REQ(N), .DATA_SIZE(DS), .TAG_SIZE(TS), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_data_ready_in      (req_ready),
        .req_data_tag_in        (req_tag),
        .req_ACK_out            (ack_out),
        .req_fail_out           (fail_out),
        .grant_out              (grant),
        .network_data_ready_out (net_ready),
        .network_data_tag_out   (net_tag),
        .network_ACK_in         (net_ack),
        .busy_out               (busy)
    );

    always #5 clk = ~clk;

    // ACK delay per send attempt, in cycles after the ready pulse; 1..TO is accepted.
    function automatic int next_d();
        int r;
        if (d_plan.size() > 0) return d_plan.pop_front();
        r = int'($urandom_range(99, 0));
        if (r < 20) return 99;
        if (r < 28) return 0;
        if (r < 36) return TO + 1;
        if (r < 46) return TO;
        return int'($urandom_range(TO, 1));
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        return r64[W-1:0];
    endfunction

    function automatic int pending_words();
        int s = 0;
        for (int i = 0; i < N; i++) s += words[i].size();
        return s;
    endfunction

    task automatic clear_logs();
        d_plan.delete();
        order_log.delete();
        outcome_log.delete();
        tries_log.delete();
        for (int i = 0; i < N; i++) words[i].delete();
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        net_ack   = 1'b0;
        req_ready = '0;
        req_tag   = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_ptr = 0;
    endtask

    task automatic raise_idle();
        for (int i = 0; i < N; i++) begin
            if (!req_ready[i] && words[i].size() > 0) begin
                req_tag[i*W +: W] = words[i][0];
                req_ready[i]      = 1'b1;
            end
        end
    endtask

    // Drives queued words through the arbiter and checks every cycle against the model.
    task automatic run_traffic(input int max_cycles);
        int g, since, d, attempt, e, cyc;
        bit arm, done, accepted, last, e_ready, e_ack, e_fail, stray;
        logic [N-1:0] oh, zero;
        logic [W-1:0] latched;
        g = -1; since = 0; d = 0; attempt = 0; cyc = 0;
        done = 1'b0; oh = '0; zero = '0; latched = '0;
        raise_idle();
        arm = (req_ready != zero);
        while (!done && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            stray = 1'b0;
            if (g >= 0) begin
                since++;
                stray = (d == TO + 1) && (since == TO + 1);
            end
            if (g < 0) begin
                if (net_ready) begin
                    e = -1;
                    for (int k = 0; k < N; k++) begin
                        if (e < 0 && req_ready[(model_ptr + k) % N]) e = (model_ptr + k) % N;
                    end
                    vectors++;
                    if (!arm || e < 0) begin
                        errors++;
                        $display("FAIL unexpected_send: send seen, arm %0d ready %b ptr %0d", arm, req_ready, model_ptr);
                    end else begin
                        oh = '0;
                        oh[e] = 1'b1;
                        if (grant !== oh || net_tag !== words[e][0] || busy !== 1'b1 ||
                            ack_out !== zero || fail_out !== zero) begin
                            errors++;
                            $display("FAIL grant_word: got grant %b word %h busy %b, expected grant %b word %h busy 1",
                                     grant, net_tag, busy, oh, words[e][0]);
                        end
                        g = e; latched = words[e][0]; attempt = 0; since = 0; d = next_d();
                        order_log.push_back(e);
                    end
                end else begin
                    vectors++;
                    if (arm || grant !== zero || busy !== 1'b0 || ack_out !== zero || fail_out !== zero) begin
                        errors++;
                        $display("FAIL idle: got ready %b grant %b busy %b ack %b fail %b, expected ready %0d and rest 0",
                                 net_ready, grant, busy, ack_out, fail_out, arm);
                    end
                    raise_idle();
                    arm = (req_ready != zero);
                    if (!arm && pending_words() == 0) done = 1'b1;
                end
            end else begin
                accepted = (d >= 1) && (d <= TO);
                last     = (attempt == MR);
                e_ack    = accepted && (since == d + 1);
                e_fail   = !accepted && last && (since == TO + 1);
                e_ready  = !accepted && !last && (since == TO + 1);
                vectors++;
                if (net_ready !== e_ready || ack_out !== (e_ack ? oh : zero) ||
                    fail_out !== (e_fail ? oh : zero) || grant !== oh || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL transfer: req %0d att %0d cyc %0d got ready %b ack %b fail %b grant %b busy %b, expected ready %0d ack %0d fail %0d grant %b",
                             g, attempt, since, net_ready, ack_out, fail_out, grant, busy, e_ready, e_ack, e_fail, oh);
                end
                if (e_ready && net_ready) begin
                    vectors++;
                    if (net_tag !== latched) begin
                        errors++;
                        $display("FAIL retry_word: got %h, expected %h", net_tag, latched);
                    end
                    attempt++; since = 0; d = next_d();
                end
                if (e_ack || e_fail) begin
                    outcome_log.push_back(e_ack ? 1 : 2);
                    tries_log.push_back(attempt + 1);
                    model_ptr = (g + 1) % N;
                    void'(words[g].pop_front());
                    req_ready[g] = 1'b0;
                    g = -1;
                    arm = 1'b0;
                end else begin
                    // The requester's inputs are free to change once the word is latched.
                    req_tag[g*W +: W] = rand_word();
                    if ($urandom_range(7, 0) == 0) req_ready[g] = 1'b0;
                end
            end
            net_ack = (g >= 0 && since == d) || stray || (g < 0 && $urandom_range(3, 0) == 0);
        end
        net_ack = 1'b0;
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL traffic_timeout: %0d words still pending after %0d cycles, expected 0", pending_words(), cyc);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++;
        if (grant !== '0 || net_ready !== 1'b0 || ack_out !== '0 || fail_out !== '0 ||
            busy !== 1'b0 || net_tag !== '0) begin
            errors++;
            $display("FAIL reset: got grant %b ready %b ack %b fail %b busy %b tag %h, expected all 0",
                     grant, net_ready, ack_out, fail_out, busy, net_tag);
        end
    endtask

    task automatic test_single();
        clear_logs();
        words[0].push_back(40'hA5A5A5A5_00);
        d_plan.push_back(3);
        run_traffic(200);
        vectors++;
        if (order_log.size() != 1 || order_log[0] != 0 || outcome_log[0] != 1 || tries_log[0] != 1) begin
            errors++;
            $display("FAIL single: got %0d grants (first %0d, outcome %0d, tries %0d), expected 1 grant to 0, ACK, 1 try",
                     order_log.size(), order_log[0], outcome_log[0], tries_log[0]);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_rr_order();
        int exp_o[4] = '{0, 1, 3, 0};
        reset_dut();
        clear_logs();
        words[0].push_back(rand_word());
        words[0].push_back(rand_word());
        words[1].push_back(rand_word());
        words[3].push_back(rand_word());
        for (int i = 0; i < 4; i++) d_plan.push_back(1);
        run_traffic(300);
        vectors++;
        if (order_log.size() != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, expected 4", order_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (order_log[i] != exp_o[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, order_log[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_never_ack();
        reset_dut();
        clear_logs();
        words[2].push_back(rand_word());
        for (int i = 0; i < 4; i++) d_plan.push_back(99);
        run_traffic(400);
        vectors++;
        if (outcome_log.size() != 1 || outcome_log[0] != 2 || tries_log[0] != MR + 1) begin
            errors++;
            $display("FAIL never_ack: got outcome %0d tries %0d, expected fail after %0d tries",
                     outcome_log[0], tries_log[0], MR + 1);
        end
        clear_logs();
        words[1].push_back(rand_word());
        words[3].push_back(rand_word());
        d_plan.push_back(2);
        d_plan.push_back(2);
        run_traffic(300);
        vectors++;
        if (order_log.size() != 2 || order_log[0] != 3 || order_log[1] != 1) begin
            errors++;
            $display("FAIL ptr_after_fail: got order %0d,%0d, expected 3,1", order_log[0], order_log[1]);
        end
    endtask

    task automatic test_ack_on_timeout();
        reset_dut();
        clear_logs();
        words[1].push_back(rand_word());
        d_plan.push_back(0);
        d_plan.push_back(TO);
        run_traffic(300);
        vectors++;
        if (outcome_log.size() != 1 || outcome_log[0] != 1 || tries_log[0] != 2) begin
            errors++;
            $display("FAIL ack_on_timeout: got outcome %0d tries %0d, expected ACK after 2 tries",
                     outcome_log[0], tries_log[0]);
        end
    endtask

    task automatic test_tag_change();
        clear_logs();
        words[3].push_back(rand_word());
        d_plan.push_back(TO + 1);
        d_plan.push_back(99);
        d_plan.push_back(7);
        run_traffic(300);
        vectors++;
        if (outcome_log.size() != 1 || outcome_log[0] != 1 || tries_log[0] != 3) begin
            errors++;
            $display("FAIL tag_change: got outcome %0d tries %0d, expected ACK after 3 tries",
                     outcome_log[0], tries_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            words[2].push_back(rand_word());
            d_plan.push_back(1);
        end
        run_traffic(200);
        vectors++;
        if (order_log.size() != 3 || order_log[0] != 2 || order_log[1] != 2 || order_log[2] != 2) begin
            errors++;
            $display("FAIL back_to_back: got %0d grants, expected 3 grants to requester 2", order_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        reset_dut();
        clear_logs();
        words[1].push_back(rand_word());
        d_plan.push_back(1);
        run_traffic(200);
        clear_logs();
        req_tag[3*W +: W] = rand_word();
        req_ready[3] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (net_ready) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_send: got no send within 10 cycles, expected one");
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_ready = '0;
        vectors++;
        if (grant !== '0 || net_ready !== 1'b0 || ack_out !== '0 || fail_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got grant %b ready %b ack %b fail %b busy %b, expected all 0",
                     grant, net_ready, ack_out, fail_out, busy);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ((ack_out | fail_out | grant) !== '0 || net_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: got ack %b fail %b grant %b, expected 0", ack_out, fail_out, grant);
            end
        end
        model_ptr = 0;
        for (int i = 1; i < N; i++) begin
            words[i].push_back(rand_word());
            d_plan.push_back(1);
        end
        run_traffic(300);
        vectors++;
        if (order_log.size() != 3 || order_log[0] != 1 || order_log[1] != 2 || order_log[2] != 3) begin
            errors++;
            $display("FAIL reset_mid_ptr: got first grant %0d of %0d, expected order 1,2,3",
                     order_log[0], order_log.size());
        end
    endtask

    task automatic test_random();
        int total;
        for (int round = 0; round < 4; round++) begin
            clear_logs();
            total = 0;
            for (int i = 0; i < N; i++) begin
                for (int j = int'($urandom_range(3, 0)); j > 0; j--) begin
                    words[i].push_back(rand_word());
                    total++;
                end
            end
            run_traffic(6000);
            vectors++;
            if (outcome_log.size() != total) begin
                errors++;
                $display("FAIL random_round%0d: got %0d completions, expected %0d", round, outcome_log.size(), total);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        net_ack = 1'b0;
        req_ready = '0;
        req_tag = '0;
        test_reset();
        test_single();
        test_rr_order();
        test_never_ack();
        test_ack_on_timeout();
        test_tag_change();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
